uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (start/data/busy handshake) between NUM_REQ byte-level requesters, e.g. LED status reporter, debug dump, command echo.
- Round-robin arbitration per byte, with optional grant lock so a requester can send a multi-byte message uninterrupted.
- Holds transmit data stable for the whole frame and detects a transmitter that never goes busy.
- Runs in the system clock domain; the UART consumes o_Tx_Start/o_Tx_Data on its divided baud tick.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
START_TIMEOUT, 20000, max system clocks o_Tx_Start may stay high without i_Tx_Busy rising (> 2 baud ticks at 8681 clocks/tick)
TIMEOUT_W, 16, width of timeout counter; must hold START_TIMEOUT

Ports:
i_Clock  in  1  system clock, all logic on rising edge
i_Reset_n  in  1  asynchronous reset, active-low
i_Req  in  NUM_REQ  per-requester request level; held high with data until acked
i_Lock  in  NUM_REQ  per-requester lock; high keeps grant after current byte if i_Req still high
i_Data  in  8*NUM_REQ  byte for requester k on bits [8k+7:8k]
o_Ack  out  NUM_REQ  one-cycle pulse: byte of requester k captured; requester may change data or drop req
o_Grant  out  NUM_REQ  one-hot owner of transmitter; all-zero when idle
o_Tx_Start  out  1  start level to UART
o_Tx_Data  out  8  byte to UART, stable from start until busy falls
i_Tx_Busy  in  1  UART busy (sync to i_Clock upstream)
o_Timeout  out  1  sticky; set on start timeout, cleared only by reset

Behaviour:
- All outputs registered. Reset values: o_Ack=0, o_Grant=0, o_Tx_Start=0, o_Tx_Data=0, o_Timeout=0; state=IDLE, rr pointer=NUM_REQ-1, timeout counter=0.
- Reset asserted mid-operation: outputs return to reset values immediately; the in-flight byte is abandoned and not re-sent.
- States: IDLE, START, BUSY.
- IDLE:
  - If locked_owner is valid and i_Req[owner] is high, select owner.
  - Otherwise, if any i_Req is high, select the first requester searching (ptr+1 .. ptr) mod NUM_REQ.
  - On select (next edge): o_Grant=onehot(sel), o_Ack[sel]=1 for one cycle, o_Tx_Data=i_Data[sel], o_Tx_Start=1, counter=0, ptr=sel, go START.
  - Latency: request visible at edge t gives outputs at t+1.
  - No request: remain IDLE with o_Grant=0.
- START:
  - Hold o_Tx_Start=1, counter+1 per clock.
  - i_Tx_Busy=1: o_Tx_Start=0, go BUSY.
  - Counter reaches START_TIMEOUT-1 with busy low: o_Tx_Start=0, o_Timeout=1, o_Grant=0, clear lock, go IDLE.
  - Busy rising on the same edge as the timeout: busy wins, no timeout.
- BUSY:
  - Hold o_Tx_Data and o_Grant.
  - On i_Tx_Busy=0: go IDLE.
  - If i_Lock[owner]=1 at that edge, record locked_owner=owner; else clear the lock.
  - o_Grant stays set into IDLE only while the lock is valid.
- Lock release: in IDLE, if the locked owner has i_Req=0, clear the lock and arbitrate normally in the same cycle.
- Simultaneous requests: exactly one o_Ack per transaction; never more than one o_Ack bit high.
- i_Req dropping after ack has no effect on the byte in flight.
- Minimum per-byte gap: one IDLE cycle between busy falling and the next o_Tx_Start.

Test Plan:
1. Reset low, i_Req=0 -> all outputs 0. Release reset, i_Req=4'b0100, i_Data[23:16]=8'hA5 -> one clock later o_Ack=4'b0100 (1 cycle), o_Grant=4'b0100, o_Tx_Data=8'hA5, o_Tx_Start=1. Busy model rises after 8681 clocks -> start drops. Busy falls after 11 ticks -> o_Grant=0.
2. i_Req=4'b1111 held, data bytes 8'h10..8'h13 -> ack/grant order 0,1,2,3,0 (pointer starts 3). Each o_Tx_Data matches the owner's byte.
3. i_Lock[1]=1, i_Req=4'b0011, requester 1 sends 3 bytes then drops req -> grants 0,1,1,1,0. Requester 0 is not served between locked bytes.
4. Busy model never responds, START_TIMEOUT=100 -> o_Tx_Start high exactly 100 clocks, then o_Timeout=1 (sticky), o_Grant=0. Next request is served normally with o_Timeout still 1.
5. Busy rises exactly on the 100th start clock -> no timeout, state BUSY.
6. Assert reset during BUSY with i_Req[2]=1 -> outputs 0 immediately. After release, requester 2 is re-arbitrated and acked again.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// requesters. A requester may lock the grant to send a multi-byte message
// without interleaving. Transmit data is held for the whole frame, and a
// transmitter that never raises busy is detected with a sticky timeout flag.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 20000,
    parameter int TIMEOUT_W     = 16
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset_n,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [NUM_REQ-1:0]     i_Lock,
    input  logic [8*NUM_REQ-1:0]   i_Data,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Tx_Start,
    output logic [7:0]             o_Tx_Data,
    input  logic                   i_Tx_Busy,
    output logic                   o_Timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY
    } state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;        // last requester served
    logic [PTR_W-1:0]       owner_q, owner_d;    // current / locked owner
    logic                   lock_valid_q, lock_valid_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   start_q, start_d;
    logic [7:0]             data_q, data_d;
    logic                   timeout_q, timeout_d;

    logic                   rr_found;
    logic [PTR_W-1:0]       rr_sel;
    logic [PTR_W-1:0]       rr_idx;
    logic                   lock_hit;
    logic [PTR_W-1:0]       sel;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] k);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Round-robin search: first active request after the last one served.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise a path that skips the assignment infers a latch.
        rr_found = 1'b0;
        rr_sel   = ptr_q;
        rr_idx   = ptr_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!rr_found && i_Req[rr_idx]) begin
                rr_found = 1'b1;
                rr_sel   = rr_idx;
            end
        end
    end

    assign lock_hit = lock_valid_q && i_Req[owner_q];

    // Next-state and registered-output logic for the IDLE/START/BUSY FSM.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        lock_valid_d = lock_valid_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        grant_d      = grant_q;
        start_d      = start_q;
        data_d       = data_q;
        timeout_d    = timeout_q;
        sel          = lock_hit ? owner_q : rr_sel;

        case (state_q)
            ST_IDLE: begin
                // A locked owner that stopped requesting releases the lock;
                // normal arbitration proceeds in the same cycle.
                if (lock_valid_q && !i_Req[owner_q]) begin
                    lock_valid_d = 1'b0;
                end
                if (lock_hit || rr_found) begin
                    grant_d  = onehot(sel);
                    ack_d    = onehot(sel);
                    data_d   = i_Data[8*sel +: 8];
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    ptr_d    = sel;
                    owner_d  = sel;
                    state_d  = ST_START;
                end else begin
                    grant_d  = '0;
                end
            end

            ST_START: begin
                // Busy has priority over a timeout expiring on the same edge.
                if (i_Tx_Busy) begin
                    start_d = 1'b0;
                    state_d = ST_BUSY;
                end else if (cnt_q == TIMEOUT_W'(START_TIMEOUT - 1)) begin
                    start_d      = 1'b0;
                    timeout_d    = 1'b1;
                    grant_d      = '0;
                    lock_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_BUSY: begin
                // End of frame: keep the grant only if the owner locks it.
                if (!i_Tx_Busy) begin
                    state_d = ST_IDLE;
                    if (i_Lock[owner_q]) begin
                        lock_valid_d = 1'b1;
                    end else begin
                        lock_valid_d = 1'b0;
                        grant_d      = '0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!i_Reset_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= PTR_W'(NUM_REQ - 1);
            owner_q      <= '0;
            lock_valid_q <= 1'b0;
            cnt_q        <= '0;
            ack_q        <= '0;
            grant_q      <= '0;
            start_q      <= 1'b0;
            data_q       <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            lock_valid_q <= lock_valid_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            grant_q      <= grant_d;
            start_q      <= start_d;
            data_q       <= data_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_Ack      = ack_q;
    assign o_Grant    = grant_q;
    assign o_Tx_Start = start_q;
    assign o_Tx_Data  = data_q;
    assign o_Timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: basic byte, round-robin order, grant
// lock, start timeout, busy-vs-timeout tie and reset during a frame.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 100;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [8*N-1:0] data;
    logic           busy;
    logic [N-1:0]   ack;
    logic [N-1:0]   grant;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           timeout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .START_TIMEOUT(TO),
        .TIMEOUT_W    (16)
    ) dut (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .i_Req     (req),
        .i_Lock    (lock),
        .i_Data    (data),
        .o_Ack     (ack),
        .o_Grant   (grant),
        .o_Tx_Start(tx_start),
        .o_Tx_Data (tx_data),
        .i_Tx_Busy (busy),
        .o_Timeout (timeout)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse away from the clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        busy  = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    // One full byte transaction: select, start, busy high, busy low.
    task automatic serve(input string tag, input int idx, input logic [7:0] byte_exp,
                         input logic [N-1:0] req_after, input logic [N-1:0] grant_after);
        logic [N-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        tick();
        check({tag, " ack"},   ack,      oh);
        check({tag, " grant"}, grant,    oh);
        check({tag, " data"},  tx_data,  byte_exp);
        check({tag, " start"}, tx_start, 1);
        req = req_after;
        tick();
        check({tag, " ack1cyc"}, ack,      0);
        check({tag, " hold"},    tx_start, 1);
        busy = 1'b1;
        tick();
        check({tag, " startoff"}, tx_start, 0);
        check({tag, " gbusy"},    grant,    oh);
        tick();
        tick();
        check({tag, " dstable"}, tx_data, byte_exp);
        busy = 1'b0;
        tick();
        check({tag, " gafter"}, grant,    grant_after);
        check({tag, " sidle"},  tx_start, 0);
    endtask

    initial begin
        int n_high;
        req   = '0;
        lock  = '0;
        data  = '0;
        busy  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;

        // 1. Reset values, then a single byte from requester 2.
        check("rst ack",     ack,      0);
        check("rst grant",   grant,    0);
        check("rst start",   tx_start, 0);
        check("rst data",    tx_data,  0);
        check("rst timeout", timeout,  0);
        tick();
        check("rst held", grant, 0);
        rst_n = 1'b1;
        req   = 4'b0100;
        data[23:16] = 8'hA5;
        serve("t1", 2, 8'hA5, 4'b0000, 4'b0000);
        tick();
        check("t1 idle ack",   ack,      0);
        check("t1 idle start", tx_start, 0);

        // 2. All four requesting: round robin from pointer 3.
        do_reset();
        req  = 4'b1111;
        data = 32'h1312_1110;
        serve("t2a", 0, 8'h10, 4'b1111, 4'b0000);
        serve("t2b", 1, 8'h11, 4'b1111, 4'b0000);
        serve("t2c", 2, 8'h12, 4'b1111, 4'b0000);
        serve("t2d", 3, 8'h13, 4'b1111, 4'b0000);
        serve("t2e", 0, 8'h10, 4'b0000, 4'b0000);

        // 3. Requester 1 locks for three bytes; requester 0 waits.
        do_reset();
        lock = 4'b0010;
        req  = 4'b0011;
        data = 32'h0000_2120;
        serve("t3a", 0, 8'h20, 4'b0011, 4'b0000);
        serve("t3b", 1, 8'h21, 4'b0011, 4'b0010);
        serve("t3c", 1, 8'h21, 4'b0011, 4'b0010);
        serve("t3d", 1, 8'h21, 4'b0001, 4'b0010);
        serve("t3e", 0, 8'h20, 4'b0000, 4'b0000);
        lock = 4'b0000;

        // 4. Transmitter never responds: start high exactly TO clocks.
        req  = 4'b1000;
        data = 32'h5C00_0000;
        tick();
        check("t4 ack",  ack,      4'b1000);
        check("t4 data", tx_data,  8'h5C);
        check("t4 to0",  timeout,  0);
        req    = 4'b0000;
        n_high = 1;
        for (int k = 0; k < 3 * TO; k++) begin
            tick();
            if (tx_start) n_high++;
            else break;
        end
        check("t4 start clocks", n_high,   TO);
        check("t4 timeout",      timeout,  1);
        check("t4 grant",        grant,    0);
        check("t4 start",        tx_start, 0);
        req  = 4'b0001;
        data = 32'h0000_0077;
        serve("t4n", 0, 8'h77, 4'b0000, 4'b0000);
        check("t4 sticky", timeout, 1);

        // 5. Busy rises on the last start clock: no timeout.
        do_reset();
        req  = 4'b0010;
        data = 32'h0000_9900;
        tick();
        check("t5 ack", ack, 4'b0010);
        req = 4'b0000;
        for (int k = 0; k < TO - 1; k++) tick();
        check("t5 start99", tx_start, 1);
        check("t5 to99",    timeout,  0);
        busy = 1'b1;
        tick();
        check("t5 startoff", tx_start, 0);
        check("t5 notimeout", timeout, 0);
        check("t5 gbusy",    grant,    4'b0010);
        tick();
        check("t5 data",     tx_data,  8'h99);
        check("t5 gbusy2",   grant,    4'b0010);
        busy = 1'b0;
        tick();
        check("t5 gafter",   grant,    0);
        check("t5 to end",   timeout,  0);

        // 6. Reset during BUSY, then requester 2 is served again.
        req  = 4'b0100;
        data = 32'h00C3_0000;
        tick();
        check("t6 ack", ack, 4'b0100);
        tick();
        busy = 1'b1;
        tick();
        check("t6 busy grant", grant, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        check("t6 rst ack",   ack,      0);
        check("t6 rst grant", grant,    0);
        check("t6 rst start", tx_start, 0);
        check("t6 rst data",  tx_data,  0);
        busy = 1'b0;
        #2 rst_n = 1'b1;
        serve("t6r", 2, 8'hC3, 4'b0000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
